// File: rtl/wb_writer_if.sv
// Bundles the pipeline result, long-latency completion and register-file write
// signals of the write-back stage.
interface wb_writer_if #(
  parameter int AW = 5
);
  logic          ex_valid;
  logic [AW-1:0] ex_waddr;
  logic [31:0]   ex_result;
  logic          mem_read;
  logic [1:0]    mem_size;
  logic          mem_unsigned;
  logic [31:0]   mem_rdata;
  logic          lo_issue;
  logic [AW-1:0] lo_issue_addr;
  logic          lo_done;
  logic [AW-1:0] lo_waddr;
  logic [31:0]   lo_result;
  logic          lo_ready;
  logic          RegWrite;
  logic [AW-1:0] waddr;
  logic [31:0]   wb_data;
  logic [31:0]   pending_mask;
  logic          hazard;

  modport slave (
    input  ex_valid, ex_waddr, ex_result, mem_read, mem_size, mem_unsigned, mem_rdata,
    input  lo_issue, lo_issue_addr, lo_done, lo_waddr, lo_result,
    output lo_ready, RegWrite, waddr, wb_data, pending_mask, hazard
  );

  modport master (
    output ex_valid, ex_waddr, ex_result, mem_read, mem_size, mem_unsigned, mem_rdata,
    output lo_issue, lo_issue_addr, lo_done, lo_waddr, lo_result,
    input  lo_ready, RegWrite, waddr, wb_data, pending_mask, hazard
  );
endinterface

// File: rtl/wb_writer.sv
// Register-file write port: merges pipeline results with buffered mult/div completions.
// Optional macro WB_FIFO_BYPASS_EN lets a completion skip the empty FIFO.
module wb_writer #(
  parameter int DEPTH = 2,
  parameter int AW    = 5
) (
  input  logic        clock,
  input  logic        reset,
  wb_writer_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } entry_t;

  entry_t        fifo_q [DEPTH];
  entry_t        head;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pending_q, pending_d;
  logic          regwrite_q, regwrite_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wb_data_q, wb_data_d;

  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_data, ex_data;
  logic          hazard_w, lo_ready_w;
  logic          ex_sel, fifo_empty, push, pop, bypass, clr_en;
  logic [AW-1:0] clr_addr;

  assign head       = fifo_q[rd_ptr_q];
  assign lo_ready_w = (count_q < FULL);
  assign hazard_w   = bus.ex_valid & (|bus.ex_waddr) & pending_q[bus.ex_waddr];

  // Little-endian load alignment and extension.
  always_comb begin
    case (bus.ex_result[1:0])
      2'd1:    byte_sel = bus.mem_rdata[15:8];
      2'd2:    byte_sel = bus.mem_rdata[23:16];
      2'd3:    byte_sel = bus.mem_rdata[31:24];
      default: byte_sel = bus.mem_rdata[7:0];
    endcase
    half_sel = bus.ex_result[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (bus.mem_size)
      2'b00:   load_data = bus.mem_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_data = bus.mem_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = bus.mem_rdata;
    endcase
    ex_data = bus.mem_read ? load_data : bus.ex_result;
  end

  always_comb begin
    ex_sel     = bus.ex_valid & (|bus.ex_waddr) & ~hazard_w;
    fifo_empty = (count_q == '0);
    pop        = ~ex_sel & ~fifo_empty;
`ifdef WB_FIFO_BYPASS_EN
    bypass     = fifo_empty & ~ex_sel & bus.lo_done;
`else
    bypass     = 1'b0;
`endif
    push       = bus.lo_done & lo_ready_w & ~bypass;

    regwrite_d = 1'b0;
    waddr_d    = waddr_q;
    wb_data_d  = wb_data_q;
    clr_en     = 1'b0;
    clr_addr   = head.addr;
    if (ex_sel) begin
      regwrite_d = 1'b1;
      waddr_d    = bus.ex_waddr;
      wb_data_d  = ex_data;
    end else if (pop) begin
      // A completion for $0 still drains its slot, just without a write.
      regwrite_d = |head.addr;
      waddr_d    = head.addr;
      wb_data_d  = head.data;
      clr_en     = 1'b1;
    end else if (bypass) begin
      regwrite_d = |bus.lo_waddr;
      waddr_d    = bus.lo_waddr;
      wb_data_d  = bus.lo_result;
      clr_en     = 1'b1;
      clr_addr   = bus.lo_waddr;
    end

    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Issue sets a bit and takes precedence over a same-cycle completion clear.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_pend
      logic set_b, clr_b;
      assign set_b = bus.lo_issue && (gi != 0) && (32'(bus.lo_issue_addr) == gi);
      assign clr_b = clr_en && (32'(clr_addr) == gi);
      assign pending_d[gi] = set_b | (pending_q[gi] & ~clr_b);
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      pending_q  <= '0;
      regwrite_q <= 1'b0;
      waddr_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      regwrite_q <= regwrite_d;
      waddr_q    <= waddr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= '{addr: bus.lo_waddr, data: bus.lo_result};
  end

  assign bus.lo_ready     = lo_ready_w;
  assign bus.RegWrite     = regwrite_q;
  assign bus.waddr        = waddr_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.pending_mask = pending_q;
  assign bus.hazard       = hazard_w;
endmodule

// File: tb/tb_wb_writer.sv
// Directed bench for wb_writer: expected register writes go into a queue and a
// monitor pops one per observed RegWrite; side signals are checked inline.
module tb_wb_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_writer_if #(.AW(5)) bus ();

  wb_writer #(.DEPTH(2), .AW(5)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  task automatic ex_req(input logic [4:0] a, input logic [31:0] r);
    bus.ex_valid  = 1'b1;
    bus.ex_waddr  = a;
    bus.ex_result = r;
    bus.mem_read  = 1'b0;
  endtask

  // Monitor: every observed register write must match the queue head.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.RegWrite === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: got r%0d=0x%08h expected no write", bus.waddr, bus.wb_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.waddr !== e.addr || bus.wb_data !== e.data) begin
            n_bad++;
            $display("FAIL wb_write: got r%0d=0x%08h expected r%0d=0x%08h",
                     bus.waddr, bus.wb_data, e.addr, e.data);
          end else begin
            $display("write r%0d=0x%08h ok", bus.waddr, bus.wb_data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Load vectors against mem_rdata 0x80FF7F01: {addr, size, unsigned, expected}.
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp;
  } ld_t;
  ld_t ld_tab [7];

  initial begin
    bit done;
    ld_tab[0] = '{32'h0000_0102, 2'b00, 1'b0, 32'hFFFF_FFFF};
    ld_tab[1] = '{32'h0000_0102, 2'b01, 1'b1, 32'h0000_80FF};
    ld_tab[2] = '{32'h0000_0100, 2'b00, 1'b1, 32'h0000_0001};
    ld_tab[3] = '{32'h0000_0103, 2'b00, 1'b0, 32'hFFFF_FF80};
    ld_tab[4] = '{32'h0000_0100, 2'b01, 1'b0, 32'h0000_7F01};
    ld_tab[5] = '{32'h0000_0103, 2'b01, 1'b0, 32'hFFFF_80FF};
    ld_tab[6] = '{32'h0000_0101, 2'b11, 1'b0, 32'h80FF_7F01};

    bus.ex_valid = 0; bus.ex_waddr = 0; bus.ex_result = 0; bus.mem_read = 0;
    bus.mem_size = 0; bus.mem_unsigned = 0; bus.mem_rdata = 0;
    bus.lo_issue = 0; bus.lo_issue_addr = 0; bus.lo_done = 0; bus.lo_waddr = 0; bus.lo_result = 0;

    step(); step();
    rst = 1'b0;
    #2;
    check("reset_regwrite", {31'b0, bus.RegWrite}, 32'd0);
    check("reset_waddr", {27'b0, bus.waddr}, 32'd0);
    check("reset_wbdata", bus.wb_data, 32'd0);
    check("reset_pending", bus.pending_mask, 32'd0);
    check("reset_lo_ready", {31'b0, bus.lo_ready}, 32'd1);

    // ALU write
    step();
    ex_req(5'd5, 32'h1234); expect_wr(5'd5, 32'h0000_1234);
    step();
    bus.ex_valid = 0;
    #2;
    check("alu_regwrite", {31'b0, bus.RegWrite}, 32'd1);
    check("alu_waddr", {27'b0, bus.waddr}, 32'd5);
    check("alu_data", bus.wb_data, 32'h0000_1234);

    // Loads, one per cycle
    for (int i = 0; i < 7; i++) begin
      ex_req(5'(10 + i), ld_tab[i].addr);
      bus.mem_read = 1'b1; bus.mem_size = ld_tab[i].size;
      bus.mem_unsigned = ld_tab[i].uns; bus.mem_rdata = 32'h80FF_7F01;
      expect_wr(5'(10 + i), ld_tab[i].exp);
      step();
    end
    bus.ex_valid = 0; bus.mem_read = 0;
    step();

    // Contention: ex busy three cycles while r8/r9 complete
    ex_req(5'd20, 32'h11); expect_wr(5'd20, 32'h11);
    bus.lo_done = 1; bus.lo_waddr = 5'd8; bus.lo_result = 32'hAA;
    step();
    ex_req(5'd21, 32'h22); expect_wr(5'd21, 32'h22);
    bus.lo_waddr = 5'd9; bus.lo_result = 32'hBB;
    step();
    ex_req(5'd22, 32'h33); expect_wr(5'd22, 32'h33);
    bus.lo_waddr = 5'd30; bus.lo_result = 32'hEE;
    #2;
    check("full_lo_ready", {31'b0, bus.lo_ready}, 32'd0);
    expect_wr(5'd8, 32'hAA); expect_wr(5'd9, 32'hBB);
    step();
    bus.ex_valid = 0; bus.lo_done = 0;
    step();
    #2;
    check("drain_first_addr", {27'b0, bus.waddr}, 32'd8);
    step();
    #2;
    check("drain_second_addr", {27'b0, bus.waddr}, 32'd9);
    check("drain_second_we", {31'b0, bus.RegWrite}, 32'd1);
    step();

    // $0 suppression lets the FIFO drain
    ex_req(5'd1, 32'h10); expect_wr(5'd1, 32'h10);
    bus.lo_done = 1; bus.lo_waddr = 5'd3; bus.lo_result = 32'h55;
    step();
    bus.lo_done = 0;
    ex_req(5'd0, 32'hDEAD); expect_wr(5'd3, 32'h55);
    step();
    #2;
    check("zero_drain_we", {31'b0, bus.RegWrite}, 32'd1);
    check("zero_drain_addr", {27'b0, bus.waddr}, 32'd3);
    bus.ex_valid = 0;
    step(); step();

    // WAW hazard on r7
    bus.lo_issue = 1; bus.lo_issue_addr = 5'd7;
    step();
    bus.lo_issue = 0;
    #2;
    check("waw_pending_set", bus.pending_mask, 32'h0000_0080);
    ex_req(5'd7, 32'h777);
    #1;
    check("waw_hazard_on", {31'b0, bus.hazard}, 32'd1);
    expect_wr(5'd7, 32'hCAFE); expect_wr(5'd7, 32'h777);
    bus.lo_done = 1; bus.lo_waddr = 5'd7; bus.lo_result = 32'hCAFE;
    step();
    bus.lo_done = 0;
    done = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      #2;
      if (bus.hazard === 1'b0) done = 1;
      else step();
    end
    check("waw_hazard_clears", {31'b0, done}, 32'd1);
    step();
    bus.ex_valid = 0;
    #2;
    check("waw_ex_written", {27'b0, bus.waddr}, 32'd7);
    check("waw_pending_clr", bus.pending_mask, 32'd0);
    step();

    // Reset with FIFO full and pending bits set
    ex_req(5'd1, 32'hA1); expect_wr(5'd1, 32'hA1);
    bus.lo_issue = 1; bus.lo_issue_addr = 5'd12;
    bus.lo_done = 1; bus.lo_waddr = 5'd12; bus.lo_result = 32'h1212;
    step();
    ex_req(5'd1, 32'hA2); expect_wr(5'd1, 32'hA2);
    bus.lo_issue_addr = 5'd13;
    bus.lo_waddr = 5'd13; bus.lo_result = 32'h1313;
    step();
    bus.lo_issue = 0; bus.lo_done = 0; bus.ex_valid = 0;
    #2;
    check("pre_reset_lo_ready", {31'b0, bus.lo_ready}, 32'd0);
    check("pre_reset_pending", bus.pending_mask, 32'h0000_3000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #2;
    check("mid_reset_regwrite", {31'b0, bus.RegWrite}, 32'd0);
    check("mid_reset_pending", bus.pending_mask, 32'd0);
    check("mid_reset_lo_ready", {31'b0, bus.lo_ready}, 32'd1);
    for (int k = 0; k < 5; k++) step();

    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_writer.md
Name: wb_writer

Overview:
- Write-back side of the register file. Produces the single write port (RegWrite, waddr, wb_data) that the decode stage's register file consumes.
- Merges two result sources onto that port:
  - the in-order pipeline result: ALU result or aligned/extended load data;
  - completions from the multi-cycle mult/div unit, buffered in a small FIFO.
- Tracks registers with outstanding long-latency writes and flags WAW hazards upstream.

Parameters:
- DEPTH, 2, number of entries in the long-latency completion FIFO (≥1).
- AW, 5, register address width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  pipeline result valid and the instruction writes a register
- ex_waddr  in  AW  pipeline destination register
- ex_result  in  32  ALU result; for loads, the byte address
- mem_read  in  1  pipeline instruction is a load
- mem_size  in  2  load size: 00 = byte, 01 = half, 10 = word
- mem_unsigned  in  1  zero-extend the load (lbu/lhu)
- mem_rdata  in  32  word read from DATA RAM or I/O
- lo_issue  in  1  long-latency op issued this cycle
- lo_issue_addr  in  AW  destination register of the issued op
- lo_done  in  1  long-latency completion valid
- lo_waddr  in  AW  completion destination register
- lo_result  in  32  completion data
- lo_ready  out  1  FIFO can accept a completion this cycle
- RegWrite  out  1  register file write enable
- waddr  out  AW  register file write address
- wb_data  out  32  register file write data
- pending_mask  out  32  bit r set while register r has an outstanding long-latency write
- hazard  out  1  pipeline write must stall (WAW against a pending register)

Behaviour:
- Reset (synchronous): RegWrite=0, waddr=0, wb_data=0, FIFO empty, pending_mask=0. A reset mid-operation discards all FIFO entries and pending bits.
- Outputs RegWrite/waddr/wb_data are registered: 1-cycle latency from the selected source.
- Load data formatting (mem_read=1), little-endian:
  - Byte: lane selected by ex_result[1:0], sign- or zero-extended per mem_unsigned.
  - Half: ex_result[1]=0 selects [15:0], 1 selects [31:16]; ex_result[0] is ignored.
  - Word: mem_rdata as-is.
  - mem_read=0: data = ex_result. mem_size=11 is treated as word.
- hazard (combinational) = ex_valid & (ex_waddr≠0) & pending_mask[ex_waddr]. While hazard=1 the ex write is not performed. Upstream holds the ex_* inputs stable until hazard drops.
- Per-cycle arbitration:
  - Priority 1: ex path, when ex_valid & ex_waddr≠0 & !hazard.
  - Priority 2: pop FIFO head (if non-empty).
  - Otherwise RegWrite=0 next cycle.
- Any write to $0 is suppressed: an ex request with ex_waddr=0 does not consume the cycle, so the FIFO may drain.
- FIFO:
  - Push when lo_done & lo_ready.
  - lo_ready = (count<DEPTH). It is not relaxed by a same-cycle pop.
  - lo_done while lo_ready=0 is ignored; the unit must hold it.
  - Simultaneous push and pop: count unchanged, order preserved.
  - An entry with lo_waddr=0 is popped without a write.
- pending_mask:
  - Set: bit lo_issue_addr on lo_issue (not for addr 0).
  - Clear: bit waddr on a FIFO pop.
  - Set and clear of the same bit in the same cycle: set wins.
- Counters and pointers wrap modulo DEPTH.

Optional Feature:
- Macro: WB_FIFO_BYPASS_EN.
- Defined: if the FIFO is empty, no ex write is selected, and lo_done=1, the completion is written directly (registered output next cycle) without entering the FIFO. Its pending bit clears that cycle. Completion-to-RegWrite latency is 1.
- Undefined: every completion is pushed first; latency is ≥2 cycles.

Test Plan:
- ALU write: ex_valid=1, ex_waddr=5, ex_result=0x1234, mem_read=0 -> next cycle RegWrite=1, waddr=5, wb_data=0x00001234.
- Load byte/half:
  - mem_rdata=0x80FF7F01, addr low bits=2, byte, signed -> wb_data=0xFFFFFFFF.
  - Same word, half, addr[1]=1, unsigned -> 0x000080FF.
- Contention: ex writes every cycle for 3 cycles while two completions (r8=0xAA, r9=0xBB) are pushed:
  - lo_ready=0 once the FIFO is full.
  - Once ex goes idle, r8 then r9 are written on consecutive cycles, in order.
- $0 suppression: ex_valid=1, ex_waddr=0 with FIFO holding r3=0x55 -> r3 is written next cycle; $0 is never written.
- WAW hazard: lo_issue r7, then ex_valid to r7 -> hazard=1 until the r7 completion is written; the ex write lands the cycle after.
- Reset mid-operation: reset with 2 FIFO entries and pending bits set -> next cycle RegWrite=0, pending_mask=0, lo_ready=1.
